// File: rtl/led_7_scan_pkg.sv
// rtl/led_7_scan_pkg.sv - shared constants for the 7-segment scan display
// Contents:
//   SSEG_OFF   segment pattern with every segment dark (active-low)
//   ANODE_OFF  level that disables a common-anode digit driver
//   HEX_GLYPH  16-entry hex glyph table, {g,f,e,d,c,b,a}, active-low
package led_7_scan_pkg;

    localparam logic [6:0] SSEG_OFF  = 7'h7F;
    localparam logic       ANODE_OFF = 1'b1;

    // Index 15 first so that HEX_GLYPH[n] is the glyph of nibble n.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/led_7_scan_if.sv
// rtl/led_7_scan_if.sv - display data in / scan drive out bundle
// Signals:
//   digits[4*N-1:0]  hex nibbles, nibble i drives digit i
//   dp[N-1:0]        decimal-point request per digit, active-high
//   blank[N-1:0]     force digit off, active-high
//   lz_en            leading-zero suppression enable
//   load             one-cycle strobe capturing the four fields above
//   anode[N-1:0]     digit enables, active-low
//   sseg[6:0]        segments {g,f,e,d,c,b,a}, active-low
//   dp_n             decimal-point segment, active-low
//   frame            one-cycle pulse when the scan wraps to digit 0
// Modports: master = data source / display sink, slave = scanner.
interface led_7_scan_if #(
    parameter int N_DIGITS = 8
);
    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blank;
    logic                  lz_en;
    logic                  load;
    logic [N_DIGITS-1:0]   anode;
    logic [6:0]            sseg;
    logic                  dp_n;
    logic                  frame;

    modport master (
        output digits, dp, blank, lz_en, load,
        input  anode, sseg, dp_n, frame
    );

    modport slave (
        input  digits, dp, blank, lz_en, load,
        output anode, sseg, dp_n, frame
    );
endinterface

// File: rtl/gm_led_7doan.sv
// rtl/gm_led_7doan.sv - hex nibble to active-low 7-segment glyph decode
// Ports:
//   so_gma[3:0]  nibble to display
//   sseg[6:0]    glyph {g,f,e,d,c,b,a}, active-low
module gm_led_7doan
    import led_7_scan_pkg::*;
(
    input  logic [3:0] so_gma,
    output logic [6:0] sseg
);

    assign sseg = HEX_GLYPH[so_gma];

endmodule

// File: rtl/led_7_scan.sv
// rtl/led_7_scan.sv - multiplexed common-anode 7-segment display scanner
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    led_7_scan_if.slave: load-strobed display data in, anode/sseg/dp_n/frame out
// Each digit owns a slot of SCAN_DIV cycles whose first BLANK_CYC cycles are dark
// to stop the previous digit's segments ghosting onto the next anode.
module led_7_scan
    import led_7_scan_pkg::*;
#(
    parameter int N_DIGITS  = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    led_7_scan_if.slave  bus
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(N_DIGITS);

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;

    // Shadow collects loads at any time; active is what the current frame shows.
    logic [4*N_DIGITS-1:0] sh_digits, act_digits;
    logic [N_DIGITS-1:0]   sh_dp, act_dp;
    logic [N_DIGITS-1:0]   sh_blank, act_blank;
    logic                  sh_lz, act_lz;

    logic                  slot_end;
    logic                  wrap;
    logic [3:0]            nibble;
    logic [6:0]            glyph;
    logic [N_DIGITS-1:0]   lz_sup;
    logic                  zero_run;
    logic [N_DIGITS-1:0]   sel;
    logic                  dark;

    assign slot_end = (cnt == CNT_W'(SCAN_DIV - 1));
    assign wrap     = slot_end && (idx == IDX_W'(N_DIGITS - 1));
    assign nibble   = act_digits[4*idx +: 4];

    gm_led_7doan u_dec (
        .so_gma (nibble),
        .sseg   (glyph)
    );

    // Walk down from the top digit; a digit is a leading zero while every digit
    // from the top down to it is zero. Digit 0 always stays lit.
    always_comb begin
        zero_run = 1'b1;
        lz_sup   = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run  = zero_run & (act_digits[4*i +: 4] == 4'h0);
            lz_sup[i] = act_lz & zero_run & (i != 0);
        end
    end

    always_comb begin
        sel      = '0;
        sel[idx] = 1'b1;
    end

    assign dark = (cnt < CNT_W'(BLANK_CYC)) | act_blank[idx] | lz_sup[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            sh_digits  <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            sh_lz      <= 1'b0;
            act_digits <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            act_lz     <= 1'b0;
            bus.anode  <= {N_DIGITS{ANODE_OFF}};
            bus.sseg   <= SSEG_OFF;
            bus.dp_n   <= 1'b1;
            bus.frame  <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= wrap ? '0 : idx + 1'b1;
            end

            if (bus.load) begin
                sh_digits <= bus.digits;
                sh_dp     <= bus.dp;
                sh_blank  <= bus.blank;
                sh_lz     <= bus.lz_en;
            end

            // Non-blocking copy takes the pre-load shadow, so a load landing on
            // the wrap cycle waits for the following frame.
            if (wrap) begin
                act_digits <= sh_digits;
                act_dp     <= sh_dp;
                act_blank  <= sh_blank;
                act_lz     <= sh_lz;
            end

            bus.frame <= wrap;
            if (dark) begin
                bus.anode <= {N_DIGITS{ANODE_OFF}};
                bus.sseg  <= SSEG_OFF;
                bus.dp_n  <= 1'b1;
            end else begin
                bus.anode <= ~sel;
                bus.sseg  <= glyph;
                bus.dp_n  <= ~act_dp[idx];
            end
        end
    end

endmodule

// File: tb/tb_led_7_scan.sv
// tb/tb_led_7_scan.sv - scoreboard bench for led_7_scan
module tb_led_7_scan;
    localparam int ND = 4, SD = 4, BC = 1, FP = ND * SD;
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_7_scan_if #(.N_DIGITS(ND)) bus();

    led_7_scan #(.N_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit         mk;       // 1 = frame pulse, 0 = lit digit
        int         edge_no;  // clock edges since reset release when it must be seen
        logic [3:0] an;
        logic [6:0] sg;
        logic       dpn;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;
    int ecnt = 0;
    logic [15:0] sh_d = '0;
    logic [3:0]  sh_p = '0, sh_b = '0;
    logic        sh_lz = 1'b0;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) ecnt <= 0; else ecnt <= ecnt + 1;

    function automatic bit suppressed(input int i);
        return sh_b[i] || (sh_lz && i > 0 && (sh_d >> (4 * i)) == 16'h0);
    endfunction

    // Expected content of frame k, taken from the loads seen before its wrap.
    task automatic push_frame(input int k);
        int w = k * FP;
        exp_t e;
        if (k > 0) begin
            e.mk = 1'b1; e.edge_no = w; e.an = 4'hF; e.sg = 7'h7F; e.dpn = 1'b1;
            q.push_back(e);
        end
        for (int i = 0; i < ND; i++) begin
            if (!suppressed(i)) begin
                for (int j = BC; j < SD; j++) begin
                    e.mk = 1'b0;
                    e.edge_no = w + i * SD + j + 1;
                    e.an = 4'hF ^ (4'b0001 << i);
                    e.sg = GLYPH[int'((sh_d >> (4 * i)) & 16'hF)];
                    e.dpn = ~sh_p[i];
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic pop_cmp(input bit mk);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s edge=%0d anode=%b sseg=%h dp_n=%b frame=%b required no output",
                     mk ? "frame" : "digit", ecnt, bus.anode, bus.sseg, bus.dp_n, bus.frame);
        end else begin
            e = q.pop_front();
            if (e.mk != mk || e.edge_no != ecnt ||
                (!mk && (e.an != bus.anode || e.sg != bus.sseg || e.dpn != bus.dp_n))) begin
                errors++;
                $display("FAIL %s actual edge=%0d anode=%b sseg=%h dp_n=%b required mk=%0d edge=%0d anode=%b sseg=%h dp_n=%b",
                         mk ? "frame" : "digit", ecnt, bus.anode, bus.sseg, bus.dp_n,
                         e.mk, e.edge_no, e.an, e.sg, e.dpn);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($countones(~bus.anode) > 1) begin
                errors++;
                $display("FAIL anode_onehot actual=%b required at most one low bit", bus.anode);
            end
            if (bus.anode != 4'hF) pop_cmp(1'b0);
            if (bus.frame) pop_cmp(1'b1);
            while (q.size() > 0 && q[0].edge_no <= ecnt) begin
                checks++;
                errors++;
                $display("FAIL missed_output actual=nothing required mk=%0d edge=%0d anode=%b",
                         q[0].mk, q[0].edge_no, q[0].an);
                q.delete(0);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit ld, input logic [15:0] d, input logic [3:0] p,
                       input logic [3:0] b, input bit lz);
        if ((ecnt + 1) % FP == 0) push_frame((ecnt + 1) / FP);
        if (ld) begin
            bus.load = 1'b1; bus.digits = d; bus.dp = p; bus.blank = b; bus.lz_en = lz;
            sh_d = d; sh_p = p; sh_b = b; sh_lz = lz;
        end else begin
            bus.load = 1'b0;
            bus.digits = 16'($urandom); bus.dp = 4'($urandom);
            bus.blank = 4'($urandom); bus.lz_en = 1'($urandom);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_until(input int target);
        while (ecnt < target) cyc(1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic rand_run(input int n);
        logic [15:0] d;
        for (int c = 0; c < n; c++) begin
            d = '0;
            for (int i = 0; i < ND; i++)
                if ($urandom_range(0, 1) == 1) d = d | (16'($urandom_range(0, 15)) << (4 * i));
            cyc($urandom_range(0, 4) == 0, d, 4'($urandom),
                ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, 1'($urandom));
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        sh_d = '0; sh_p = '0; sh_b = '0; sh_lz = 1'b0;
        rst_n = 1'b1;
        push_frame(0);
    endtask

    initial begin
        bus.digits = '0; bus.dp = '0; bus.blank = '0; bus.lz_en = 1'b0; bus.load = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_anode", 32'(bus.anode), 32'hF);
        chk("reset_sseg", 32'(bus.sseg), 32'h7F);
        chk("reset_dp_n", 32'(bus.dp_n), 32'h1);
        chk("reset_frame", 32'(bus.frame), 32'h0);
        release_reset();

        cyc(1'b1, 16'h1234, 4'h0, 4'h0, 1'b0);
        idle_until(48);
        cyc(1'b1, 16'h0045, 4'h0, 4'h0, 1'b1);
        idle_until(80);
        cyc(1'b1, 16'h0000, 4'h0, 4'h0, 1'b1);
        idle_until(119);
        cyc(1'b1, 16'hABCD, 4'h0, 4'h0, 1'b0);       // mid-frame load
        idle_until(150);
        cyc(1'b1, 16'h5678, 4'b0001, 4'b0010, 1'b0);
        idle_until(175);
        cyc(1'b1, 16'h9999, 4'b1000, 4'h0, 1'b0);    // sampled on the wrap edge
        idle_until(224);

        rand_run(600);

        cyc(1'b1, 16'h4321, 4'h0, 4'h0, 1'b0);
        idle_until((ecnt / FP + 2) * FP);
        while (ecnt % FP != 10) cyc(1'b0, '0, '0, '0, 1'b0);
        chk("pre_reset_digit2", 32'(bus.anode), 32'hB);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_anode", 32'(bus.anode), 32'hF);
        chk("async_reset_sseg", 32'(bus.sseg), 32'h7F);
        chk("async_reset_dp_n", 32'(bus.dp_n), 32'h1);
        chk("async_reset_frame", 32'(bus.frame), 32'h0);
        q.delete();
        @(posedge clk);
        release_reset();
        cyc(1'b0, '0, '0, '0, 1'b0);
        chk("restart_blank_window", 32'(bus.anode), 32'hF);
        cyc(1'b0, '0, '0, '0, 1'b0);
        chk("restart_digit0", 32'(bus.anode), 32'hE);

        rand_run(300);

        chk("scoreboard_drained", 32'(q.size() <= 1 + ND * (SD - BC)), 32'h1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/led_7_scan.md
LED_7_SCAN -- requirements
Module: led_7_scan

Interface
REQ-001 Parameter N_DIGITS, default 8, number of common-anode digits scanned (2..16).
REQ-002 Parameter SCAN_DIV, default 50000, clock cycles each digit slot lasts (>= BLANK_CYC+2).
REQ-003 Parameter BLANK_CYC, default 16, all-off cycles at the start of each slot (anti-ghosting).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: ports clk and rst_n.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 digits  input  4*N_DIGITS  hex nibbles; nibble i drives digit i; digit 0 is least significant.
REQ-008 dp  input  N_DIGITS  decimal-point request per digit, active-high.
REQ-009 blank  input  N_DIGITS  force digit off, active-high.
REQ-010 lz_en  input  1  leading-zero suppression enable.
REQ-011 load  input  1  single-cycle strobe; captures digits, dp, blank and lz_en into the shadow register.
REQ-012 anode  output  N_DIGITS  digit enables, active-low.
REQ-013 sseg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-014 dp_n  output  1  decimal-point segment, active-low.
REQ-015 frame  output  1  one-cycle pulse when the digit index wraps to 0.

Function
REQ-016 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; the digit index SHALL advance on terminal count, wrapping N_DIGITS-1 -> 0.
REQ-017 Shadow register SHALL capture the inputs on any cycle with load=1; a load on the same cycle as the wrap SHALL be captured into the shadow register only.
REQ-018 The active register SHALL copy the shadow register only on index wrap (frame boundary); a mid-frame load SHALL never alter the current frame.
REQ-019 For prescaler < BLANK_CYC, anode SHALL be all ones; otherwise exactly the current-index bit SHALL be 0, unless that digit is suppressed.
REQ-020 A digit SHALL be suppressed when its active blank bit = 1, or when lz_en = 1 and it and all higher digits are 0; digit 0 SHALL never be zero-suppressed.
REQ-021 A suppressed digit SHALL drive anode all ones, sseg 7'h7F, and dp_n 1.
REQ-022 sseg SHALL be the standard hex glyph of the current nibble: 0->7'h40, 1->7'h79, 8->7'h00, F->7'h0E.
REQ-023 dp_n SHALL equal ~dp[index] for a displayed digit.
REQ-024 anode, sseg, dp_n and frame SHALL be registered, with 1 cycle latency from prescaler/index state.
REQ-025 frame SHALL assert for exactly one cycle per N_DIGITS*SCAN_DIV cycles.
REQ-026 Exactly one anode bit SHALL be 0 at any time, or none.

Reset
REQ-027 On rst_n=0: prescaler 0, index 0, shadow and active registers 0, anode all ones, sseg 7'h7F, dp_n 1, frame 0.
REQ-028 Reset asserted mid-slot SHALL blank the display immediately (asynchronously); after release, scanning SHALL restart at digit 0 with a full blanking window.

Structure
REQ-029 A shared package SHALL hold the 16-entry hex glyph constants, the SSEG_OFF constant (7'h7F) and the ANODE_OFF convention.
REQ-030 The hex-to-segment decode SHALL be the sub-module gm_led_7doan (ports so_gma[3:0], sseg[6:0]), instantiated once on the muxed nibble.
REQ-031 The prescaler, index counter, shadow/active registers, suppression logic and output registers SHALL remain in led_7_scan.

Verification
REQ-032 N_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, load digits=16'h1234, dp=0, lz_en=0 -> after the next frame, anode cycles 1110,1101,1011,0111 (3 cycles each, 1 cycle 1111 between), sseg cycles 4,3,2,1 glyphs.
REQ-033 digits=16'h0045, lz_en=1 -> digits 3 and 2 stay off; digits 1 and 0 show 4 and 5; digits=16'h0000 -> only digit 0 shows 7'h40.
REQ-034 load 16'hABCD mid-frame -> current frame unchanged; new values appear starting at the cycle after frame pulses.
REQ-035 blank=4'b0010, dp=4'b0001 -> digit 1 never enabled; dp_n=0 only while digit 0 is enabled.
REQ-036 rst_n pulled low during digit 2 -> anode 1111 and sseg 7'h7F without waiting for a clock edge; after release, first enabled digit is 0 after BLANK_CYC cycles.
REQ-037 Checker over 10000 cycles -> at most one anode bit low, and frame period exactly 16 cycles.
